mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Data-memory bus controller downstream of the processor's data-memory port. It accepts single-cycle read/write dispatches with a byte/half/word width and drives a word-wide synchronous BRAM with byte enables. It returns right-justified, zero-extended load data and holds `busy` until the access retires. Sign extension stays in the processor.

## Interface
- `ADDR_WIDTH`, default 12: BRAM word-address width (depth 2^ADDR_WIDTH × 32 bits).
- `READ_LATENCY`, default 2: BRAM cycles from address registered to `bram_rdata_in` valid; legal range 1–4.
- `clk_in` in 1: single clock.
- `rst_n_in` in 1: reset, asynchronous assert, active-low.
- `dispatch_read_in` in 1: one-cycle load request.
- `dispatch_write_in` in 1: one-cycle store request.
- `addr_in` in 32: byte address, sampled on dispatch.
- `mem_width_in` in `mem::width_t`: BYTE (8), WORD (16), DWORD (32), sampled on dispatch.
- `write_data_in` in 32: store data, right-justified, sampled on dispatch.
- `busy_out` out 1: access in flight.
- `read_data_out` out 32: load result, zero-extended.
- `fault_out` out 1: one-cycle pulse on a rejected request.
- `bram_addr_out` out ADDR_WIDTH: word address, `addr[ADDR_WIDTH+1:2]`.
- `bram_we_out` out 4: byte write enables.
- `bram_wdata_out` out 32: lane-replicated store data.
- `bram_rdata_in` in 32: BRAM read data.

## Operation
- States: IDLE, READ_WAIT, READ_DONE, WRITE.
- `busy_out` = `(state != IDLE) | dispatch_read_in | dispatch_write_in`. It is combinational so the requester sees busy in the dispatch cycle itself.
- **IDLE + read dispatch:** latch addr, width, `addr[1:0]`. Drive `bram_addr_out`, load counter with READ_LATENCY-1, go to READ_WAIT.
- **READ_WAIT:** count down to 0, then go to READ_DONE.
- **READ_DONE:** extract lane:
  - BYTE: `rdata >> (8*addr[1:0])` & 0xFF.
  - WORD: `rdata >> (16*addr[1])` & 0xFFFF.
  - DWORD: unmodified.
  - Register result into `read_data_out`, go to IDLE.
- **IDLE + write dispatch:** go to WRITE.
  - `bram_wdata_out` = `{4{d[7:0]}}` / `{2{d[15:0]}}` / `d` by width.
  - `bram_we_out` = `4'b0001 << addr[1:0]` for BYTE, `4'b0011 << (2*addr[1])` for WORD, `4'b1111` for DWORD.
  - `bram_we_out` is nonzero for exactly the one WRITE cycle; then go to IDLE.
- **Rejected requests:** pulse `fault_out` next cycle, make no BRAM access, remain or return to IDLE, leave `read_data_out` unchanged.
  - Misaligned: WORD with `addr[0]`=1, or DWORD with `addr[1:0]`≠0.
  - Both dispatches high in the same cycle.
  - Any dispatch while state ≠ IDLE. The in-flight access completes unaffected.
- Address bits above `ADDR_WIDTH+1` are ignored; addresses alias with no fault.

## Timing
- Reset values: state IDLE, `busy_out` 0 (absent dispatch), `read_data_out` 0, `fault_out` 0, `bram_addr_out` 0, `bram_we_out` 0, `bram_wdata_out` 0.
- Reset asserted mid-access aborts it immediately: `bram_we_out` drops to 0 asynchronously and no write occurs after release.
- **Read:** dispatch in cycle 0. `busy_out` is high in cycles 0..READ_LATENCY+1. `read_data_out` is valid and `busy_out` low from cycle READ_LATENCY+2 (cycle 4 at default). `read_data_out` holds until the next completed read.
- **Write:** dispatch in cycle 0. `bram_we_out` is nonzero in cycle 1, `busy_out` is high in cycles 0–1, and the controller is ready for a new dispatch in cycle 2.
- **Fault:** `fault_out` is high in cycle 1. A dispatch rejected from IDLE leaves `busy_out` high in cycle 0 only.
- A new dispatch is accepted in the first cycle `busy_out` would otherwise be low. Back-to-back accesses are therefore supported with no idle gap.

## Structure
- Shared package `mem`: `width_t` enum (BYTE, WORD, DWORD), already used by the processor's memory bus.
- Add to `mem`: `mem_ctrl_state_t`, plus helper functions `lane_we(width, off)` and `lane_extract(width, off, data)`.
- Sub-module: none. The BRAM is instantiated by the parent and connected through the `bram_*` ports.

## Test plan
- **DWORD store then load:** write 0xDEADBEEF @0x10, read @0x10 → `bram_we_out`=1111, `read_data_out`=0xDEADBEEF at cycle 4 after the read dispatch.
- **Byte lanes:** store BYTE 0xA5 @0x13 over 0x11223344 → `we`=1000, `wdata`=0xA5A5A5A5. Word then reads 0xA5223344; BYTE load @0x13 returns 0x000000A5.
- **Halfword:** store WORD 0xBEEF @0x22 → `we`=1100. WORD load @0x22 → 0x0000BEEF; WORD load @0x20 → old low half.
- **Faults:**
  - WORD load @0x21 → `fault_out` pulse at cycle 1, `bram_we_out`=0, `read_data_out` unchanged.
  - Simultaneous read+write dispatch → fault, no access.
- **Busy protocol:** dispatch a read at cycle 0 and a write at cycle 2 → write rejected with fault, read completes with correct data. Back-to-back write/write/read sequence completes with no gaps.
- **Reset mid-read:** deassert `rst_n_in` in cycle 2 of a read → all outputs return to reset values immediately. After release, the first dispatch behaves normally.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared data-memory bus types and byte-lane helpers
package mem;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    WORD  = 2'd1,
    DWORD = 2'd2
  } width_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    READ_DONE = 2'd2,
    WRITE     = 2'd3
  } mem_ctrl_state_t;

  function automatic logic [3:0] lane_we(width_t width, logic [1:0] off);
    case (width)
      BYTE:    return 4'b0001 << off;
      WORD:    return 4'b0011 << {off[1], 1'b0};
      DWORD:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(width_t width, logic [1:0] off, logic [31:0] data);
    logic [31:0] shifted;
    case (width)
      BYTE: begin
        shifted = data >> {off, 3'b000};
        return {24'h0, shifted[7:0]};
      end
      WORD: begin
        shifted = data >> {off[1], 4'b0000};
        return {16'h0, shifted[15:0]};
      end
      default: return data;
    endcase
  endfunction

  // Store data is replicated to every lane so byte enables alone select the target.
  function automatic logic [31:0] lane_replicate(width_t width, logic [31:0] data);
    case (width)
      BYTE:    return {4{data[7:0]}};
      WORD:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - data-memory bus controller driving a word-wide byte-enabled BRAM
module mem_bus_ctrl
  import mem::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  dispatch_read_in,
  input  logic                  dispatch_write_in,
  input  logic [31:0]           addr_in,
  input  width_t                mem_width_in,
  input  logic [31:0]           write_data_in,
  output logic                  busy_out,
  output logic [31:0]           read_data_out,
  output logic                  fault_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [3:0]            bram_we_out,
  output logic [31:0]           bram_wdata_out,
  input  logic [31:0]           bram_rdata_in
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

  mem_ctrl_state_t state, state_next;
  width_t          width_q;
  logic [1:0]      off_q;
  logic [1:0]      cnt;
  logic            misaligned;
  logic            reject;
  logic            accept_read;
  logic            accept_write;

  // High address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^addr_in[31:ADDR_WIDTH+2];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    misaligned   = 1'b0;
    reject       = 1'b0;
    accept_read  = 1'b0;
    accept_write = 1'b0;
    busy_out     = (state != IDLE) | dispatch_read_in | dispatch_write_in;
    state_next   = state;

    case (mem_width_in)
      BYTE:    misaligned = 1'b0;
      WORD:    misaligned = addr_in[0];
      DWORD:   misaligned = |addr_in[1:0];
      default: misaligned = 1'b1;
    endcase

    reject = (dispatch_read_in | dispatch_write_in) &
             ((dispatch_read_in & dispatch_write_in) | (state != IDLE) | misaligned);
    accept_read  = dispatch_read_in & ~reject;
    accept_write = dispatch_write_in & ~reject;

    case (state)
      IDLE: begin
        if (accept_read)       state_next = READ_WAIT;
        else if (accept_write) state_next = WRITE;
      end
      READ_WAIT: if (cnt == 2'd0) state_next = READ_DONE;
      READ_DONE: state_next = IDLE;
      WRITE:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      width_q        <= BYTE;
      off_q          <= 2'd0;
      cnt            <= 2'd0;
      fault_out      <= 1'b0;
      read_data_out  <= 32'h0;
      bram_addr_out  <= '0;
      bram_we_out    <= 4'h0;
      bram_wdata_out <= 32'h0;
    end else begin
      fault_out   <= reject;
      bram_we_out <= 4'h0;
      if (accept_read || accept_write) begin
        bram_addr_out <= addr_in[ADDR_WIDTH+1:2];
        width_q       <= mem_width_in;
        off_q         <= addr_in[1:0];
      end
      if (accept_read)                           cnt <= LAT_INIT;
      else if (state == READ_WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (accept_write) begin
        bram_we_out    <= lane_we(mem_width_in, addr_in[1:0]);
        bram_wdata_out <= lane_replicate(mem_width_in, write_data_in);
      end
      if (state == READ_DONE) read_data_out <= lane_extract(width_q, off_q, bram_rdata_in);
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl with a behavioural BRAM
module tb_mem_bus_ctrl;
  import mem::*;

  localparam int AW = 12;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dispatch_read;
  logic          dispatch_write;
  logic [31:0]   addr;
  width_t        mem_width;
  logic [31:0]   write_data;
  logic          busy;
  logic [31:0]   read_data;
  logic          fault;
  logic [AW-1:0] bram_addr;
  logic [3:0]    bram_we;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  logic [7:0]  model[int];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .dispatch_read_in(dispatch_read), .dispatch_write_in(dispatch_write),
    .addr_in(addr), .mem_width_in(mem_width), .write_data_in(write_data),
    .busy_out(busy), .read_data_out(read_data), .fault_out(fault),
    .bram_addr_out(bram_addr), .bram_we_out(bram_we),
    .bram_wdata_out(bram_wdata), .bram_rdata_in(bram_rdata)
  );

  logic [31:0] bram    [0:(1<<AW)-1];
  logic [31:0] rd_pipe [0:RL-1];

  always @(posedge clk) begin
    rd_pipe[0] <= bram[bram_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    for (int b = 0; b < 4; b++)
      if (bram_we[b]) bram[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
  end
  assign bram_rdata = rd_pipe[RL-1];

  function automatic int nbytes(width_t w);
    case (w)
      BYTE:    return 1;
      WORD:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int mask_addr(logic [31:0] a);
    return int'(a & ((32'd1 << (AW + 2)) - 32'd1));
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] a, width_t w);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(w); i++) begin
      int ba = mask_addr(a) + i;
      v[8*i +: 8] = model.exists(ba) ? model[ba] : 8'h00;
    end
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; dispatch_read = 1'b0; dispatch_write = 1'b0;
    addr = 32'h0; mem_width = BYTE; write_data = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, fault, bram_we, bram_addr, read_data, bram_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b fault=%b we=%h addr=%h rdata=%h wdata=%h required all zero",
               busy, fault, bram_we, bram_addr, read_data, bram_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input width_t w, input logic [31:0] d);
    logic [3:0]    exp_we = 4'h0;
    logic [31:0]   exp_wd = 32'h0;
    logic [AW-1:0] exp_ba = AW'(mask_addr(a) >> 2);
    int n = nbytes(w);
    for (int i = 0; i < n; i++) exp_we[int'(a[1:0]) + i] = 1'b1;
    for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = d[8*(b % n) +: 8];
    dispatch_write = 1'b1; addr = a; mem_width = w; write_data = d;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy_c0: got %b required 1", busy); end
    @(negedge clk);
    dispatch_write = 1'b0;
    #1;
    checks++;
    if ({bram_we, bram_wdata, bram_addr, busy, fault} !== {exp_we, exp_wd, exp_ba, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wr_c1 @%h: got we=%b wdata=%h addr=%h busy=%b fault=%b required we=%b wdata=%h addr=%h busy=1 fault=0",
               a, bram_we, bram_wdata, bram_addr, busy, fault, exp_we, exp_wd, exp_ba);
    end
    for (int b = 0; b < 4; b++)
      if (exp_we[b]) model[(mask_addr(a) & ~3) + b] = exp_wd[8*b +: 8];
    @(negedge clk);
    #1;
    checks++;
    if ({bram_we, busy} !== 5'b0) begin
      errors++;
      $display("FAIL wr_c2 @%h: got we=%b busy=%b required we=0000 busy=0", a, bram_we, busy);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input width_t w);
    int cyc = 0;
    logic [31:0] exp;
    exp_q.push_back(model_load(a, w));
    dispatch_read = 1'b1; addr = a; mem_width = w;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy_c0: got %b required 1", busy); end
    @(negedge clk);
    dispatch_read = 1'b0;
    cyc = 1;
    #1;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
      #1;
    end
    checks++;
    if (cyc != RL + 2) begin
      errors++;
      $display("FAIL rd_latency @%h: got busy low at cycle %0d required cycle %0d", a, cyc, RL + 2);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL rd_scoreboard: got empty queue required one entry");
    end else begin
      exp = exp_q.pop_front();
      if (read_data !== exp) begin
        errors++;
        $display("FAIL rd_data @%h w=%s: got %h required %h", a, w.name(), read_data, exp);
      end
      last_rd = exp;
    end
  endtask

  task automatic do_fault(input logic r, input logic wr, input logic [31:0] a, input width_t w);
    dispatch_read = r; dispatch_write = wr; addr = a; mem_width = w; write_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL flt_busy_c0: got %b required 1", busy); end
    @(negedge clk);
    dispatch_read = 1'b0; dispatch_write = 1'b0;
    #1;
    checks++;
    if ({fault, bram_we, busy, read_data} !== {1'b1, 4'h0, 1'b0, last_rd}) begin
      errors++;
      $display("FAIL flt_c1 r=%b w=%b @%h: got fault=%b we=%b busy=%b rdata=%h required fault=1 we=0000 busy=0 rdata=%h",
               r, wr, a, fault, bram_we, busy, read_data, last_rd);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fault !== 1'b0) begin errors++; $display("FAIL flt_c2: got fault=%b required 0", fault); end
  endtask

  task automatic test_dword();
    do_write(32'h10, DWORD, 32'hDEAD_BEEF);
    do_read(32'h10, DWORD);
    checks++;
    if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL dword_const: got %h required deadbeef", read_data); end
  endtask

  task automatic test_byte_lanes();
    do_write(32'h10, DWORD, 32'h1122_3344);
    do_write(32'h13, BYTE, 32'h0000_00A5);
    do_read(32'h10, DWORD);
    checks++;
    if (read_data !== 32'hA522_3344) begin errors++; $display("FAIL byte_merge: got %h required a5223344", read_data); end
    do_read(32'h13, BYTE);
    checks++;
    if (read_data !== 32'h0000_00A5) begin errors++; $display("FAIL byte_load: got %h required 000000a5", read_data); end
    for (int off = 0; off < 4; off++) do_read(32'h10 + off, BYTE);
    do_read(32'h4010, DWORD);
  endtask

  task automatic test_halfword();
    do_write(32'h20, DWORD, 32'hCAFE_1234);
    do_write(32'h22, WORD, 32'h0000_BEEF);
    do_read(32'h22, WORD);
    checks++;
    if (read_data !== 32'h0000_BEEF) begin errors++; $display("FAIL half_hi: got %h required 0000beef", read_data); end
    do_read(32'h20, WORD);
    checks++;
    if (read_data !== 32'h0000_1234) begin errors++; $display("FAIL half_lo: got %h required 00001234", read_data); end
  endtask

  task automatic test_faults();
    do_fault(1'b1, 1'b0, 32'h21, WORD);
    do_fault(1'b1, 1'b0, 32'h12, DWORD);
    do_fault(1'b1, 1'b1, 32'h10, DWORD);
    do_fault(1'b0, 1'b1, 32'h23, WORD);
    do_fault(1'b0, 1'b1, 32'h22, DWORD);
    do_read(32'h20, DWORD);
  endtask

  task automatic test_busy();
    logic [31:0] exp;
    exp_q.push_back(model_load(32'h10, DWORD));
    dispatch_read = 1'b1; addr = 32'h10; mem_width = DWORD;
    @(negedge clk);
    dispatch_read = 1'b0;
    @(negedge clk);
    dispatch_write = 1'b1; addr = 32'h10; mem_width = DWORD; write_data = 32'h0BAD_0BAD;
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_c2: got %b required 1", busy); end
    @(negedge clk);
    dispatch_write = 1'b0;
    #1;
    checks++;
    if ({fault, bram_we} !== {1'b1, 4'h0}) begin
      errors++;
      $display("FAIL busy_reject: got fault=%b we=%b required fault=1 we=0000", fault, bram_we);
    end
    @(negedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({busy, fault, read_data} !== {1'b0, 1'b0, exp}) begin
      errors++;
      $display("FAIL busy_read_done: got busy=%b fault=%b rdata=%h required busy=0 fault=0 rdata=%h",
               busy, fault, read_data, exp);
    end
    last_rd = exp;
    do_read(32'h10, DWORD);
  endtask

  task automatic test_back_to_back();
    do_write(32'h40, DWORD, 32'h0102_0304);
    do_write(32'h41, BYTE, 32'h0000_00EE);
    do_read(32'h40, DWORD);
    checks++;
    if (read_data !== 32'h0102_EE04) begin errors++; $display("FAIL b2b_const: got %h required 0102ee04", read_data); end
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63));
      width_t w = width_t'(2'($urandom_range(0, 2)));
      if (w == WORD)  a[0]   = 1'b0;
      if (w == DWORD) a[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) do_write(a, w, $urandom);
      else                           do_read(a, w);
    end
  endtask

  task automatic test_reset_mid();
    do_write(32'h30, DWORD, 32'h5566_7788);
    do_read(32'h30, DWORD);
    dispatch_read = 1'b1; addr = 32'h30; mem_width = DWORD;
    @(negedge clk);
    dispatch_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, fault, bram_we, bram_addr, read_data, bram_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_read: got busy=%b fault=%b we=%h addr=%h rdata=%h wdata=%h required all zero",
               busy, fault, bram_we, bram_addr, read_data, bram_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 32'h0;
    #1;
    dispatch_write = 1'b1; addr = 32'h30; mem_width = DWORD; write_data = 32'h1234_5678;
    @(negedge clk);
    dispatch_write = 1'b0;
    #1;
    checks++;
    if (bram_we !== 4'hF) begin errors++; $display("FAIL rst_wr_pending: got we=%b required 1111", bram_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bram_we !== 4'h0) begin errors++; $display("FAIL rst_wr_abort: got we=%b required 0000", bram_we); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    do_read(32'h30, DWORD);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = 32'h0;
    test_reset();
    test_dword();
    test_byte_lanes();
    test_halfword();
    test_faults();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
